// File: rtl/fifo_rd_prefetch_pkg.sv
// Shared constants for the FIFO read prefetch block: widths, skid depth and stall counter limit.
package fifo_rd_prefetch_pkg;

    localparam int PF_DAT_WIDTH  = 32;
    localparam int PF_SKID_DEPTH = 2;
    localparam int OCC_W         = 2;
    localparam int STALL_W       = 16;

    localparam logic [OCC_W-1:0]   OCC_FULL      = 2'd2;
    localparam logic [STALL_W-1:0] STALL_CNT_MAX = 16'hFFFF;

    function automatic logic [STALL_W-1:0] stall_sat_inc(input logic [STALL_W-1:0] cnt);
        return (cnt == STALL_CNT_MAX) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry FIFO-ordered output buffer; head entry is presented from registers.
module fifo_rd_skid_buf
    import fifo_rd_prefetch_pkg::*;
#(
    parameter int DAT_WIDTH = PF_DAT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic [DAT_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic                 valid,
    output logic [DAT_WIDTH-1:0] head_data,
    output logic [OCC_W-1:0]     occ
);

    logic [DAT_WIDTH-1:0] mem [PF_SKID_DEPTH];
    logic                 head;
    logic                 tail;

    // Flush outranks both capture and pop; the capture slot is simply not written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            occ    <= '0;
        end else if (flush) begin
            head <= 1'b0;
            tail <= 1'b0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign valid     = (occ != '0);
    assign head_data = mem[head];

    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && !flush && (occ == OCC_FULL)));

endmodule

// File: rtl/fifo_rd_prefetch_a64d32.sv
// Turns the 1-cycle-latency RAM FIFO read into a valid/ready stream with a 2-entry skid buffer.
// Optional stall statistics counter enabled by FIFO_RD_PREFETCH_STATS_EN.
module fifo_rd_prefetch_a64d32
    import fifo_rd_prefetch_pkg::*;
#(
    parameter int DAT_WIDTH  = PF_DAT_WIDTH,
    parameter int SKID_DEPTH = PF_SKID_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_op,
    input  logic [DAT_WIDTH-1:0] fifo_rd_data,
    input  logic                 fifo_rd_empty_err,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DAT_WIDTH-1:0] out_data,
    output logic                 err_sticky,
    output logic [STALL_W-1:0]   stall_cnt
);

    logic             pop;
    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_after;

    assign pop = out_valid && out_ready;

    // Slots committed after this edge: buffered + word arriving - word leaving (max 3 fits 2 bits).
    assign occ_after  = occ + {1'b0, inflight} - {1'b0, pop};
    assign fifo_rd_op = reset_n && !fifo_empty && !flush && (occ_after < OCC_FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_op;
        end
    end

    fifo_rd_skid_buf #(
        .DAT_WIDTH (DAT_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .valid     (out_valid),
        .head_data (out_data),
        .occ       (occ)
    );

    // A new error in the flush cycle must survive the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else if (fifo_rd_empty_err) begin
            err_sticky <= 1'b1;
        end else if (flush) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef FIFO_RD_PREFETCH_STATS_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready) begin
            stall_q <= stall_sat_inc(stall_q);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assert property (@(posedge clk) disable iff (!reset_n) occ <= OCC_W'(SKID_DEPTH));

endmodule

// File: tb/tb_fifo_rd_prefetch_a64d32.sv
// Randomized and directed bench for fifo_rd_prefetch_a64d32 against a queue-based reference model.
module tb_fifo_rd_prefetch_a64d32;

`ifdef FIFO_RD_PREFETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fifo_empty;
    logic        fifo_rd_op;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_empty_err;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        err_sticky;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] up_q[$];
    logic [31:0] m_buf[$];
    bit          m_inflight;
    bit          m_err;
    int          m_stall;
    logic [31:0] m_ram;
    logic [31:0] seq;

    bit          s_rd, s_valid, s_err;
    logic [31:0] s_data;
    logic [15:0] s_stall;

    fifo_rd_prefetch_a64d32 dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .fifo_empty        (fifo_empty),
        .fifo_rd_op        (fifo_rd_op),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_rd_empty_err (fifo_rd_empty_err),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .err_sticky        (err_sticky),
        .stall_cnt         (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // One clock cycle: drive inputs, compare against model, advance model to the next edge.
    task automatic step(bit rdy, bit fl, bit er);
        bit e_valid, pop, e_rd;
        int committed;
        fifo_empty        = (up_q.size() == 0);
        out_ready         = rdy;
        flush             = fl;
        fifo_rd_empty_err = er;
        fifo_rd_data      = m_ram;
        #1;
        e_valid   = (m_buf.size() != 0);
        pop       = e_valid && rdy;
        committed = m_buf.size() + int'(m_inflight) - int'(pop);
        e_rd      = !fifo_empty && !fl && (committed < 2);

        s_rd = fifo_rd_op; s_valid = out_valid; s_err = err_sticky;
        s_data = out_data; s_stall = stall_cnt;

        chk1("rd_op", fifo_rd_op, e_rd);
        chk1("out_valid", out_valid, e_valid);
        if (e_valid) chk32("out_data", out_data, m_buf[0]);
        chk1("err_sticky", err_sticky, m_err);
        chk32("stall_cnt", {16'd0, stall_cnt}, STATS ? 32'(m_stall) : 32'd0);

        if (fl) begin
            m_buf.delete();
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (m_inflight) m_buf.push_back(m_ram);
        end
        m_inflight = e_rd;
        if (er) m_err = 1'b1;
        else if (fl) m_err = 1'b0;
        if (fl) m_stall = 0;
        else if (e_valid && !rdy && m_stall < 65535) m_stall++;
        if (e_rd) m_ram = up_q.pop_front();
        else m_ram = $urandom;
        @(negedge clk);
    endtask

    task automatic do_reset(string tag);
        reset_n           = 1'b0;
        fifo_empty        = 1'b0;
        flush             = 1'b0;
        fifo_rd_empty_err = 1'b0;
        out_ready         = 1'b1;
        #1;
        chk1({tag, "_rd_op"}, fifo_rd_op, 1'b0);
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chk32({tag, "_data"}, out_data, 32'd0);
        chk1({tag, "_err"}, err_sticky, 1'b0);
        chk32({tag, "_stall"}, {16'd0, stall_cnt}, 32'd0);
        m_buf.delete();
        up_q.delete();
        m_inflight = 1'b0;
        m_err      = 1'b0;
        m_stall    = 0;
        m_ram      = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic random_run(int n);
        for (int i = 0; i < n; i++) begin
            if (up_q.size() < 64 && $urandom_range(0, 99) < 60) begin
                up_q.push_back(seq);
                seq++;
            end
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 2);
        end
    endtask

    initial begin
        int cnt;
        seq               = 32'h0000_1000;
        reset_n           = 1'b0;
        fifo_empty        = 1'b1;
        flush             = 1'b0;
        fifo_rd_empty_err = 1'b0;
        out_ready         = 1'b0;
        fifo_rd_data      = 32'd0;
        @(negedge clk);
        do_reset("reset");

        // Four preloaded words streamed with out_ready held high.
        for (int w = 0; w < 4; w++) up_q.push_back(32'hA0 + 32'(w));
        for (int c = 1; c <= 8; c++) begin
            step(1'b1, 1'b0, 1'b0);
            chk1("a0_rd_op", s_rd, c <= 4);
            chk1("a0_valid", s_valid, (c >= 3) && (c <= 6));
            if (c >= 3 && c <= 6) chk32("a0_data", s_data, 32'hA0 + 32'(c - 3));
        end

        // Backpressure: exactly two reads, head frozen, then lossless drain.
        for (int w = 0; w < 6; w++) up_q.push_back(32'hB0 + 32'(w));
        cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, 1'b0, 1'b0);
            cnt += int'(s_rd);
            if (c >= 3) chk32("bp_frozen", s_data, 32'hB0);
        end
        chk32("bp_rd_count", 32'(cnt), 32'd2);
        for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 1'b0);

        // Sticky error held for 100 cycles, then flush interactions.
        step(1'b1, 1'b0, 1'b1);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            step(1'b1, 1'b0, 1'b0);
            cnt += int'(s_err);
        end
        chk32("err_hold", 32'(cnt), 32'd100);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk1("err_set_wins", s_err, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk1("err_flush_clr", s_err, 1'b0);

        // Flush in the cycle after a read drops the in-flight word.
        up_q.push_back(32'hC0);
        step(1'b1, 1'b0, 1'b0);
        chk1("fl_rd_issued", s_rd, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk1("fl_valid0", s_valid, 1'b0);
        chk1("fl_err0", s_err, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk1("fl_valid0_b", s_valid, 1'b0);

        // Full-rate streaming with a never-empty upstream.
        do_reset("reset2");
        cnt = 0;
        for (int c = 1; c <= 24; c++) begin
            up_q.push_back(seq);
            seq++;
            step(1'b1, 1'b0, 1'b0);
            if (c >= 3) cnt += int'(s_valid);
        end
        chk32("throughput", 32'(cnt), 32'd22);

        random_run(3000);
        #3;
        do_reset("reset_mid");
        random_run(500);

        // Long stall: counter saturates when enabled, stays zero otherwise.
        do_reset("reset3");
        for (int w = 0; w < 3; w++) up_q.push_back(32'hD0 + 32'(w));
        for (int c = 0; c < (STATS ? 70000 : 300); c++) step(1'b0, 1'b0, 1'b0);
        chk32("stall_sat", {16'd0, s_stall}, STATS ? 32'h0000_FFFF : 32'd0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk32("stall_flush", {16'd0, s_stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
